nibble_fifo: RTL and testbench

NIBBLE_FIFO -- requirements
Module: nibble_fifo

---
 rtl/nibble_fifo_pkg.sv | 26 ++
 rtl/nibble_fifo_mem.sv | 27 ++
 rtl/nibble_fifo.sv | 92 +++++++++
 tb/tb_nibble_fifo.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/nibble_fifo_pkg.sv
// Shared constants for the weekly lab blocks: default FIFO geometry and
// the helpers that derive pointer/count widths from a depth.
package nibble_fifo_pkg;

    localparam int unsigned FIFO_WIDTH = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned FIFO_CNT_W = FIFO_PTR_W + 1;

    // Accepted-operation class for one clock edge.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_WR   = 2'b01,
        OP_RD   = 2'b10,
        OP_WRRD = 2'b11
    } op_e;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/nibble_fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module nibble_fifo_mem
    import nibble_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [$clog2(DEPTH)-1:0]  waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0]  raddr,
    output logic [WIDTH-1:0]          rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/nibble_fifo.sv
// Single-clock FIFO controller: pointers, occupancy count, status flags,
// sticky overflow and a registered read-data output with a valid pulse.
module nibble_fifo
    import nibble_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      Ce,
    input  logic [WIDTH-1:0]          Din,
    input  logic                      Rd,
    output logic [WIDTH-1:0]          Dout,
    output logic                      DoutV,
    output logic                      Empty,
    output logic                      Full,
    output logic [$clog2(DEPTH):0]    Count,
    output logic                      Ovf
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rdata;
    logic             rd_acc;
    logic             wr_acc;
    op_e              op;

    assign Empty = (count == '0);
    assign Full  = (count == FULL_CNT);
    assign Count = count;

    // A full FIFO is never empty, so a simultaneous read always frees the slot.
    assign rd_acc = Rd && !Empty;
    assign wr_acc = Ce && (!Full || rd_acc);

    always_comb begin
        op = OP_IDLE;
        unique case ({rd_acc, wr_acc})
            2'b01:   op = OP_WR;
            2'b10:   op = OP_RD;
            2'b11:   op = OP_WRRD;
            default: op = OP_IDLE;
        endcase
    end

    nibble_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (CLK),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata (Din),
        .raddr (rptr),
        .rdata (rdata)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            Dout  <= '0;
            DoutV <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            DoutV <= rd_acc;
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr <= rptr + 1'b1;
                Dout <= rdata;
            end
            unique case (op)
                OP_WR:   count <= count + 1'b1;
                OP_RD:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (Ce && !wr_acc) begin
                Ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nibble_fifo.sv
// Directed self-checking bench for nibble_fifo at WIDTH=4, DEPTH=4.
module tb_nibble_fifo;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Ce  = 1'b0;
    logic [3:0] Din = '0;
    logic       Rd  = 1'b0;
    logic [3:0] Dout;
    logic       DoutV;
    logic       Empty;
    logic       Full;
    logic [2:0] Count;
    logic       Ovf;

    int unsigned errors = 0;
    int unsigned checks = 0;

    nibble_fifo #(
        .WIDTH (4),
        .DEPTH (4)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .Ce    (Ce),
        .Din   (Din),
        .Rd    (Rd),
        .Dout  (Dout),
        .DoutV (DoutV),
        .Empty (Empty),
        .Full  (Full),
        .Count (Count),
        .Ovf   (Ovf)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one edge's worth of inputs, then settle 1 time unit past the edge.
    task automatic step(input logic r, input logic ce, input logic [3:0] d, input logic rd);
        RST = r;
        Ce  = ce;
        Din = d;
        Rd  = rd;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        Ce  = 1'b0;
        Rd  = 1'b0;
    endtask

    task automatic wr(input logic [3:0] d);
        step(1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic rd_expect(input string tag, input logic [3:0] v);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        chk({tag, ".dout"}, 32'(Dout), 32'(v));
        chk({tag, ".doutv"}, 32'(DoutV), 1);
    endtask

    task automatic status(input string tag, input int unsigned cnt,
                          input int unsigned emp, input int unsigned ful, input int unsigned ovf);
        chk({tag, ".count"}, 32'(Count), cnt);
        chk({tag, ".empty"}, 32'(Empty), emp);
        chk({tag, ".full"}, 32'(Full), ful);
        chk({tag, ".ovf"}, 32'(Ovf), ovf);
    endtask

    initial begin
        #1;
        step(1'b1, 1'b0, 4'h0, 1'b0);
        status("reset", 0, 1, 0, 0);
        chk("reset.doutv", 32'(DoutV), 0);
        chk("reset.dout", 32'(Dout), 0);

        wr(4'h1); wr(4'h2); wr(4'h4); wr(4'h8);
        status("fill", 4, 0, 1, 0);

        rd_expect("drain0", 4'h1);
        rd_expect("drain1", 4'h2);
        rd_expect("drain2", 4'h4);
        rd_expect("drain3", 4'h8);
        status("drained", 0, 1, 0, 0);

        step(1'b0, 1'b0, 4'h0, 1'b0);
        chk("idle.doutv", 32'(DoutV), 0);
        chk("idle.dout_hold", 32'(Dout), 8);

        wr(4'h1); wr(4'h2); wr(4'h4); wr(4'h8);
        step(1'b0, 1'b1, 4'hF, 1'b0);
        status("ovf", 4, 0, 1, 1);
        rd_expect("ovf_drain0", 4'h1);
        rd_expect("ovf_drain1", 4'h2);
        rd_expect("ovf_drain2", 4'h4);
        rd_expect("ovf_drain3", 4'h8);
        status("ovf_drained", 0, 1, 0, 1);

        step(1'b0, 1'b0, 4'h0, 1'b1);
        chk("rd_empty.count", 32'(Count), 0);
        chk("rd_empty.doutv", 32'(DoutV), 0);
        chk("rd_empty.dout", 32'(Dout), 8);

        step(1'b0, 1'b1, 4'h3, 1'b1);
        chk("empty_wr_rd.count", 32'(Count), 1);
        chk("empty_wr_rd.doutv", 32'(DoutV), 0);
        rd_expect("empty_wr_rd.next", 4'h3);
        chk("empty_wr_rd.count_after", 32'(Count), 0);

        // Pointers sit at 1 here, so six writes carry them past DEPTH-1.
        wr(4'h5); wr(4'h6);
        rd_expect("wrap_r0", 4'h5);
        wr(4'h7); wr(4'h9);
        rd_expect("wrap_r1", 4'h6);
        wr(4'hA);
        rd_expect("wrap_r2", 4'h7);
        wr(4'hB);
        status("wrap", 3, 0, 0, 1);

        wr(4'hC);
        status("refull", 4, 0, 1, 1);
        step(1'b0, 1'b1, 4'hD, 1'b1);
        chk("full_wr_rd.dout", 32'(Dout), 9);
        chk("full_wr_rd.doutv", 32'(DoutV), 1);
        status("full_wr_rd", 4, 0, 1, 1);
        rd_expect("full_drain0", 4'hA);
        rd_expect("full_drain1", 4'hB);
        rd_expect("full_drain2", 4'hC);
        rd_expect("full_drain3", 4'hD);
        status("full_drained", 0, 1, 0, 1);

        wr(4'h1); wr(4'h2);
        chk("pre_rst.count", 32'(Count), 2);
        step(1'b1, 1'b0, 4'h0, 1'b1);
        status("rst_rd", 0, 1, 0, 0);
        chk("rst_rd.doutv", 32'(DoutV), 0);
        chk("rst_rd.dout", 32'(Dout), 0);

        wr(4'hE);
        rd_expect("post_rst", 4'hE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
